// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci stream checker: FSM state encodings,
// default widths and the wrapped-sum helper used to form the expected sample.
package fib_pkg;

  localparam int FIB_WIDTH_DEF = 8;
  localparam int FIB_CNT_W_DEF = 16;

  // State encodings; ERR is only reachable in the sticky-error build.
  localparam logic [1:0] PRIME0 = 2'd0;
  localparam logic [1:0] PRIME1 = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] ERR    = 2'd3;

  // Sum of the two history samples reduced mod 2^w; the carry out of bit w-1
  // is discarded, so callers only ever look at the low w bits.
  function automatic logic [63:0] fib_next(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
    logic [63:0] mask;
    if (w >= 32'd64) mask = '1;
    else             mask = (64'd1 << w) - 64'd1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/fib_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a long-running monitor never reports a misleadingly small count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}}) return v;
    return v + W'(1);
  endfunction

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i)    count_d = '0;
    else if (inc_i) count_d = sat_inc(count_q);
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fib_checker.sv
// Fibonacci stream checker. Primes on the first two accepted samples, then
// checks every further sample against the wrapped sum of the previous two.
// Build option: define FIB_CHECKER_STICKY_ERR_EN to make a mismatch park the
// checker in ERR (error held, in_ready low) until reset or sync_clear; without
// it error is a one-cycle pulse and the history resynchronises to the stream.
module fib_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sync_clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] p0_q, p0_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic             ready_q, ready_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d;
  logic [WIDTH-1:0] err_act_q, err_act_d;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             accept;
  logic [WIDTH-1:0] exp_w;

  assign accept = in_valid && ready_q;
  assign exp_w  = WIDTH'(fib_next(64'(p1_q), 64'(p0_q), WIDTH));

  // Next-state, history and status update for one accepted sample or clear.
  always_comb begin
    state_d   = state_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    locked_d  = locked_q;
`ifdef FIB_CHECKER_STICKY_ERR_EN
    error_d   = error_q;
`else
    error_d   = 1'b0;
`endif
    err_exp_d = err_exp_q;
    err_act_d = err_act_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;

    if (sync_clear) begin
      // Restart priming; a same-cycle sample becomes the first prime value.
      state_d  = PRIME0;
      p0_d     = '0;
      p1_d     = '0;
      locked_d = 1'b0;
      error_d  = 1'b0;
      cnt_clr  = 1'b1;
      if (accept) begin
        p1_d    = in_data;
        state_d = PRIME1;
      end
    end else if (accept) begin
      case (state_q)
        PRIME0: begin
          p1_d    = in_data;
          state_d = PRIME1;
        end
        PRIME1: begin
          p0_d    = p1_q;
          p1_d    = in_data;
          state_d = CHECK;
        end
        CHECK: begin
          if (in_data == exp_w) begin
            p0_d     = p1_q;
            p1_d     = in_data;
            cnt_inc  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_exp_d = exp_w;
            err_act_d = in_data;
            locked_d  = 1'b0;
            error_d   = 1'b1;
`ifdef FIB_CHECKER_STICKY_ERR_EN
            state_d   = ERR;
`else
            p0_d      = p1_q;
            p1_d      = in_data;
`endif
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

`ifdef FIB_CHECKER_STICKY_ERR_EN
    ready_d = (state_d != ERR);
`else
    ready_d = 1'b1;
`endif
  end

  // State, history and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PRIME0;
      p0_q      <= '0;
      p1_q      <= '0;
      ready_q   <= 1'b0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      err_exp_q <= '0;
      err_act_q <= '0;
    end else begin
      state_q   <= state_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      ready_q   <= ready_d;
      locked_q  <= locked_d;
      error_q   <= error_d;
      err_exp_q <= err_exp_d;
      err_act_q <= err_act_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear_i (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (match_count)
  );

  assign in_ready     = ready_q;
  assign locked       = locked_q;
  assign error        = error_q;
  assign err_expected = err_exp_q;
  assign err_actual   = err_act_q;

endmodule

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: the driver queues the expected status for
// every sample it hands over; the monitor pops and compares one cycle after
// each accepted sample. A second instance with CNT_W=2 shares the stimulus.
module tb_fib_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sync_clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        in_ready, locked, error;
  logic [15:0] match_count;
  logic [7:0]  err_expected, err_actual;

  logic        in_ready_s, locked_s, error_s;
  logic [1:0]  match_count_s;
  logic [7:0]  err_expected_s, err_actual_s;

  typedef struct {
    logic        lk;
    logic        er;
    logic [15:0] cnt;
    logic [7:0]  ee;
    logic [7:0]  ea;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_acc;
  exp_t mon_e;
  logic [7:0] ee_keep, ea_keep;

  fib_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .sync_clear(sync_clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .locked(locked), .error(error), .match_count(match_count),
    .err_expected(err_expected), .err_actual(err_actual)
  );

  fib_checker #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .sync_clear(sync_clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .locked(locked_s), .error(error_s), .match_count(match_count_s),
    .err_expected(err_expected_s), .err_actual(err_actual_s)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: a sample accepted on this edge must show its result 1 time unit later.
  always @(posedge clock) begin
    mon_acc = in_valid && in_ready && !reset;
    #1;
    if (mon_acc) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("locked", {31'd0, locked}, {31'd0, mon_e.lk});
        chk("error", {31'd0, error}, {31'd0, mon_e.er});
        chk("match_count", {16'd0, match_count}, {16'd0, mon_e.cnt});
        chk("err_expected", {24'd0, err_expected}, {24'd0, mon_e.ee});
        chk("err_actual", {24'd0, err_actual}, {24'd0, mon_e.ea});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic clr, input logic lk,
                      input logic er, input int cnt, input logic [7:0] ee,
                      input logic [7:0] ea);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      in_valid   = 1'b1;
      sync_clear = clr;
      in_data    = d;
      sb.push_back('{lk, er, 16'(cnt), ee, ea});
      @(posedge clock);
      #2;
      in_valid   = 1'b0;
      sync_clear = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    sync_clear = 1'b1;
    @(posedge clock);
    #2;
    sync_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_match_count", {16'd0, match_count}, 32'd0);
    chk("rst_err_expected", {24'd0, err_expected}, 32'd0);
    chk("rst_err_actual", {24'd0, err_actual}, 32'd0);
    reset = 1'b0;
    chk("rst_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #2;
    chk("rst_ready_rise", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fibs [10];
    logic [7:0] wrap [6];
    logic [7:0] gap  [11];
    fibs = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};
    wrap = '{8'd89, 8'd144, 8'd233, 8'd121, 8'd98, 8'd219};
    gap  = '{8'd3, 8'd4, 8'd7, 8'd11, 8'd18, 8'd29, 8'd47, 8'd76, 8'd123, 8'd199, 8'd66};

    idle(2);
    do_reset();

    // Continuous Fibonacci stream.
    for (int i = 0; i < 10; i++) begin
      send(fibs[i], 1'b0, i >= 2, 1'b0, (i >= 2) ? i - 1 : 0, 8'd0, 8'd0);
      if (i == 3) chk("sat_cnt_mid", {30'd0, match_count_s}, 32'd2);
    end
    chk("fib_count", {16'd0, match_count}, 32'd8);
    chk("sat_cnt_sat", {30'd0, match_count_s}, 32'd3);
    chk("sat_locked", {31'd0, locked_s}, 32'd1);
    chk("sat_error", {31'd0, error_s}, 32'd0);
    chk("sat_ready", {31'd0, in_ready_s}, 32'd1);
    chk("sat_err_regs", {16'd0, err_expected_s, err_actual_s}, 32'd0);

    // Clear, then a stream that crosses the 8-bit wrap point.
    pulse_clear();
    chk("clr_locked", {31'd0, locked}, 32'd0);
    chk("clr_count", {16'd0, match_count}, 32'd0);
    for (int i = 0; i < 6; i++)
      send(wrap[i], 1'b0, i >= 2, 1'b0, (i >= 2) ? i - 1 : 0, 8'd0, 8'd0);

    // Mismatch: 1,2,3,5,9 expects 8 at the last sample.
    pulse_clear();
    send(8'd1, 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    send(8'd2, 1'b0, 1'b0, 1'b0, 0, 8'd0, 8'd0);
    send(8'd3, 1'b0, 1'b1, 1'b0, 1, 8'd0, 8'd0);
    send(8'd5, 1'b0, 1'b1, 1'b0, 2, 8'd0, 8'd0);
    send(8'd9, 1'b0, 1'b0, 1'b1, 2, 8'd8, 8'd9);
`ifdef FIB_CHECKER_STICKY_ERR_EN
    chk("err_ready_low", {31'd0, in_ready}, 32'd0);
    idle(3);
    chk("err_sticky", {31'd0, error}, 32'd1);
    chk("err_ready_held", {31'd0, in_ready}, 32'd0);
    do_reset();
    ee_keep = 8'd0;
    ea_keep = 8'd0;
`else
    send(8'd14, 1'b0, 1'b1, 1'b0, 3, 8'd8, 8'd9);
    send(8'd23, 1'b0, 1'b1, 1'b0, 4, 8'd8, 8'd9);
    chk("err_pulse_gone", {31'd0, error}, 32'd0);
    ee_keep = 8'd8;
    ea_keep = 8'd9;
`endif

    // sync_clear together with a valid sample: 7 becomes the first prime.
    send(8'd7, 1'b1, 1'b0, 1'b0, 0, ee_keep, ea_keep);
    send(8'd7, 1'b0, 1'b0, 1'b0, 0, ee_keep, ea_keep);
    send(8'd14, 1'b0, 1'b1, 1'b0, 1, ee_keep, ea_keep);
    send(8'd21, 1'b0, 1'b1, 1'b0, 2, ee_keep, ea_keep);

    // Reset in the middle of CHECK.
    do_reset();

    // Correct stream with random gaps in in_valid.
    for (int i = 0; i < 11; i++) begin
      idle($urandom_range(0, 3));
      send(gap[i], 1'b0, i >= 2, 1'b0, (i >= 2) ? i - 1 : 0, 8'd0, 8'd0);
    end
    chk("gap_count", {16'd0, match_count}, 32'd9);

    idle(3);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_checker.md
Name: fib_checker

Overview:
- Stream consumer that verifies a Fibonacci-style sequence, such as the 8-bit counter output sampled once per clock.
- Takes samples over a valid/ready handshake and primes on the first two accepted samples.
- From the third sample on, checks each sample against (prev + prev2) mod 2^WIDTH.
- Reports lock, match count and mismatch details; used as a self-checking monitor in benches and on-chip.

Parameters:
WIDTH, 8, sample width; all arithmetic is mod 2^WIDTH
CNT_W, 16, width of match counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
sync_clear  in  1  restart priming without full reset
in_valid  in  1  sample present
in_data  in  WIDTH  sample value
in_ready  out  1  checker can accept sample
locked  out  1  at least one checked sample matched since last prime; no mismatch since
error  out  1  mismatch indication (see Optional Feature)
match_count  out  CNT_W  matched samples since reset/clear, saturating
err_expected  out  WIDTH  expected value at last mismatch
err_actual  out  WIDTH  received value at last mismatch

Behaviour:
- Interface: reset synchronous, active-high; clock is clock.
- Accept condition: a sample is accepted on a rising edge where in_valid && in_ready.
- All outputs are registered.
- Reset values: in_ready=0, locked=0, error=0, match_count=0, err_expected=0, err_actual=0; state=PRIME0; history regs p0=p1=0.
- in_ready rises 1 cycle after reset deasserts. It stays 1 in every state except ERR.
- States and transitions:
  - PRIME0: on accept, p1<=in_data; go to PRIME1.
  - PRIME1: on accept, p0<=p1, p1<=in_data; go to CHECK.
  - CHECK: on accept, compute exp=(p1+p0) mod 2^WIDTH using a WIDTH+1-bit add with the carry dropped.
    - Match: p0<=p1, p1<=in_data; match_count += 1 (saturates at 2^CNT_W-1); locked<=1.
    - Mismatch: err_expected<=exp, err_actual<=in_data, locked<=0; next state per Optional Feature.
  - ERR (sticky build only): in_ready=0; no sample consumed; held until reset or sync_clear.
- Check latency: result of a sample is visible on the outputs the cycle after acceptance.
- No-op cycles: cycles without accept leave all state unchanged; gaps in in_valid are legal.
- sync_clear:
  - Next state PRIME0; clears locked, error, match_count and history. err_expected and err_actual are retained.
  - Has priority over a same-cycle accept. That sample is consumed (in_ready was 1), becomes the PRIME0 sample, and the next state is PRIME1.
  - In ERR: sync_clear returns to PRIME0 and in_ready=1 the next cycle.
- Reset: reset mid-stream or mid-ERR fully restores reset values and overrides sync_clear.
- Wrap-around: arithmetic wraps mod 2^WIDTH, e.g. 144,233 -> expects 121; 233,121 -> expects 98. Wrapped values are matches, not errors.
- Priming samples: never checked, so any two values prime legally, including 0,0 (expects 0 thereafter).

Optional Feature:
- Macro: FIB_CHECKER_STICKY_ERR_EN.
- Defined: a mismatch sets error=1 and enters ERR. error stays 1 and in_ready stays 0 until reset or sync_clear.
- Undefined:
  - error is a 1-cycle pulse per mismatch and the checker stays in CHECK.
  - Resynchronisation: history shifts to the received value (p0<=p1, p1<=in_data) and checking continues.
  - ERR state is not built.

Decomposition:
- Package fib_pkg: state enum (PRIME0, PRIME1, CHECK, ERR), default WIDTH/CNT_W localparams, and function fib_next(a,b) returning the WIDTH-bit wrapped sum.
- Natural sub-module: sat_counter (parameterised width, inc, clear, saturating), used for match_count.
- Compare/state logic stays in fib_checker.

Test Plan:
- Continuous stream from the Fibonacci counter (1,2,3,5,8,13,...) after reset -> locked=1 after 3rd sample; match_count=N-2 after N samples; error never asserted.
- Stream across the wrap point 89,144,233,121,98,219 -> all matches, no error; match_count=4.
- Stream 1,2,3,5,9 -> error set the cycle after 9 accepted; err_expected=8, err_actual=9; locked=0.
  - Sticky build: in_ready=0 thereafter.
  - Non-sticky build: following 14,23 both match and match_count continues from 2.
- sync_clear asserted with in_valid and in_data=7, then 7,14,21 -> 7 consumed as PRIME0; with next 7 primes 7,7; then 14,21 match; match_count=2.
- Reset asserted mid-ERR (sticky) and mid-CHECK -> all outputs at reset values next cycle; in_ready=1 one cycle after reset drops.
- Random in_valid gaps on a correct stream, and CNT_W=2 with a 10-sample correct stream -> no errors; match_count saturates at 3.
